order_sched: RTL and testbench



---
 rtl/order_sched_pkg.sv | 33 +++
 rtl/order_sched_rr_arbiter.sv | 46 ++++
 rtl/order_sched.sv | 173 +++++++++++++++++
 tb/tb_order_sched.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/order_sched_pkg.sv
// Shared types and constants for the order scheduler slice: FSM states,
// MsgSeqNum wrap value and the field layout of a requester's order bundle.
package order_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_LAST = 2'd2,
    ST_GAP       = 2'd3
  } state_t;

  // MsgSeqNum never takes the value 0; it restarts here after all-ones.
  localparam logic [31:0] SEQ_WRAP_VAL = 32'd1;

  localparam int REQ_W_DEFAULT = 96;

  // Layout of one requester's req_data slice (LSB offsets and widths).
  localparam int ORD_ID_LSB = 0;
  localparam int ORD_ID_W   = 32;
  localparam int PRICE_LSB  = 32;
  localparam int PRICE_W    = 32;
  localparam int QTY_LSB    = 64;
  localparam int QTY_W      = 16;
  localparam int SIDE_LSB   = 80;
  localparam int SIDE_W     = 1;
  localparam int SYM_LSB    = 81;
  localparam int SYM_W      = 15;

  function automatic logic [31:0] seq_next(input logic [31:0] seq);
    return (seq == 32'hFFFF_FFFF) ? SEQ_WRAP_VAL : seq + 32'd1;
  endfunction

endpackage

// File: rtl/order_sched_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from pointer+1 (mod
// NUM_REQ) for the first active request. The pointer register lives in the parent.
module order_sched_rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_ptr,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IW-1:0]      o_idx,
  output logic               o_any
);

  logic          w_found;
  logic [IW-1:0] w_j;

  assign o_any = |i_req;

  // Priority search starting just above the last winner.
  always_comb begin
    o_idx   = '0;
    w_found = 1'b0;
    w_j     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_j = IW'((int'(i_ptr) + k) % NUM_REQ);
      if (!w_found && i_req[w_j]) begin
        w_found = 1'b1;
        o_idx   = w_j;
      end else begin
        w_found = w_found;
      end
    end
  end

  // One-hot acceptance strobe, only while the parent allows a launch.
  always_comb begin
    o_grant = '0;
    if (i_en && o_any) begin
      o_grant[o_idx] = 1'b1;
    end else begin
      o_grant = '0;
    end
  end

endmodule

// File: rtl/order_sched.sv
// Order scheduler: round-robin grant, MsgSeqNum assignment and one-cycle
// launch pulse to the frame builder. Optional launch-rate limit: ORDER_THROTTLE_EN.
module order_sched
  import order_sched_pkg::*;
#(
  parameter int          NUM_REQ         = 4,
  parameter int          REQ_W           = REQ_W_DEFAULT,
  parameter logic [31:0] SEQ_INIT        = 32'd1,
  parameter int          GAP_CYCLES      = 2,
  parameter int          TIMEOUT         = 8,
  parameter int          THROTTLE_WINDOW = 1024,
  parameter int          THROTTLE_MAX    = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*REQ_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       tx_ready,
  input  logic                       pl_tlast,
  input  logic                       pl_tvalid,
  output logic                       pl_enable,
  output logic [31:0]                pl_seq_num,
  output logic [REQ_W-1:0]           pl_req_data,
  output logic [$clog2(NUM_REQ)-1:0] pl_grant_id,
  output logic                       busy,
  output logic [31:0]                frames_sent,
  output logic                       timeout_err
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t           r_state;
  logic [IW-1:0]    r_ptr;
  logic [TW-1:0]    r_to_cnt;
  logic [GW-1:0]    r_gap_cnt;
  logic             r_pl_enable;
  logic [31:0]      r_seq;
  logic [REQ_W-1:0] r_req_data;
  logic [IW-1:0]    r_grant_id;
  logic             r_busy;
  logic [31:0]      r_frames;
  logic             r_timeout_err;

  logic             w_any;
  logic             w_throttled;
  logic             w_launch_ok;
  logic             w_tlast_hit;
  logic [IW-1:0]    w_idx;
  logic [REQ_W-1:0] w_sel_data;

  assign w_launch_ok = (r_state == ST_IDLE) & w_any & tx_ready & ~w_throttled;
  assign w_tlast_hit = pl_tvalid & pl_tlast;
  assign w_sel_data  = req_data[int'(w_idx)*REQ_W +: REQ_W];

  order_sched_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .i_en    (w_launch_ok),
    .o_grant (req_ready),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

`ifdef ORDER_THROTTLE_EN
  localparam int WW = (THROTTLE_WINDOW > 1) ? $clog2(THROTTLE_WINDOW) : 1;
  localparam int LW = $clog2(THROTTLE_MAX + 1);
  localparam logic [WW-1:0] WIN_LAST = WW'(THROTTLE_WINDOW - 1);

  logic [WW-1:0] r_win_cnt;
  logic [LW-1:0] r_launch_cnt;

  // Rate window: a launch landing on the wrap cycle counts toward the new window.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_win_cnt    <= '0;
      r_launch_cnt <= '0;
    end else if (r_win_cnt == WIN_LAST) begin
      r_win_cnt    <= '0;
      r_launch_cnt <= (r_state == ST_LAUNCH) ? LW'(1) : '0;
    end else begin
      r_win_cnt    <= r_win_cnt + WW'(1);
      r_launch_cnt <= (r_state == ST_LAUNCH) ? r_launch_cnt + LW'(1) : r_launch_cnt;
    end
  end

  assign w_throttled = (r_launch_cnt == LW'(THROTTLE_MAX));
`else
  assign w_throttled = 1'b0;
`endif

  // Scheduler FSM with all builder-facing outputs registered.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state       <= ST_IDLE;
      r_ptr         <= IW'(NUM_REQ - 1);
      r_to_cnt      <= '0;
      r_gap_cnt     <= '0;
      r_pl_enable   <= 1'b0;
      r_seq         <= SEQ_INIT;
      r_req_data    <= '0;
      r_grant_id    <= '0;
      r_busy        <= 1'b0;
      r_frames      <= 32'd0;
      r_timeout_err <= 1'b0;
    end else begin
      r_pl_enable <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_launch_ok) begin
            r_req_data  <= w_sel_data;
            r_grant_id  <= w_idx;
            r_ptr       <= w_idx;
            r_pl_enable <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= ST_LAUNCH;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_LAUNCH: begin
          r_to_cnt <= '0;
          r_state  <= ST_WAIT_LAST;
        end
        ST_WAIT_LAST: begin
          // A timed-out frame still consumes its sequence number.
          if (w_tlast_hit || (r_to_cnt == TO_LAST)) begin
            r_seq     <= seq_next(r_seq);
            r_gap_cnt <= '0;
            if (w_tlast_hit) begin
              r_frames <= r_frames + 32'd1;
            end else begin
              r_timeout_err <= 1'b1;
            end
            if (GAP_CYCLES == 0) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_GAP;
            end
          end else begin
            r_to_cnt <= r_to_cnt + TW'(1);
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt + GW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign pl_enable   = r_pl_enable;
  assign pl_seq_num  = r_seq;
  assign pl_req_data = r_req_data;
  assign pl_grant_id = r_grant_id;
  assign busy        = r_busy;
  assign frames_sent = r_frames;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_order_sched.sv
// Scoreboard bench for order_sched: launches are checked by a monitor against
// expectations queued by the directed stimulus.
module tb_order_sched;

  localparam int NREQ = 4;
  localparam int RW   = 96;

  typedef struct {
    logic [1:0]    id;
    logic [31:0]   seq;
    logic [RW-1:0] data;
  } exp_t;

  logic              clk;
  logic              resetn;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*RW-1:0] req_data;
  logic [NREQ-1:0]   req_ready, w_req_ready;
  logic              tx_ready, pl_tlast, pl_tvalid;
  logic              pl_enable, w_pl_enable;
  logic [31:0]       pl_seq_num, w_pl_seq_num;
  logic [RW-1:0]     pl_req_data, w_pl_req_data;
  logic [1:0]        pl_grant_id, w_pl_grant_id;
  logic              busy, w_busy;
  logic [31:0]       frames_sent, w_frames_sent;
  logic              timeout_err, w_timeout_err;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];
  bit   withhold = 1'b0;
  bit   spacing_on = 1'b0;

  order_sched u_dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_ready(tx_ready), .pl_tlast(pl_tlast),
    .pl_tvalid(pl_tvalid), .pl_enable(pl_enable), .pl_seq_num(pl_seq_num),
    .pl_req_data(pl_req_data), .pl_grant_id(pl_grant_id), .busy(busy),
    .frames_sent(frames_sent), .timeout_err(timeout_err)
  );

  // Second instance starts at the top of the sequence space to exercise the wrap.
  order_sched #(.SEQ_INIT(32'hFFFF_FFFF)) u_dut_wrap (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_data(req_data),
    .req_ready(w_req_ready), .tx_ready(tx_ready), .pl_tlast(pl_tlast),
    .pl_tvalid(pl_tvalid), .pl_enable(w_pl_enable), .pl_seq_num(w_pl_seq_num),
    .pl_req_data(w_pl_req_data), .pl_grant_id(w_pl_grant_id), .busy(w_busy),
    .frames_sent(w_frames_sent), .timeout_err(w_timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [RW-1:0] exp_data(input int i);
    logic [31:0] a, b, c;
    a = 32'h0A00_0000 + i;
    b = 32'h0000_1000 * (i + 1);
    c = 32'hC0DE_0000 + i;
    return {a, b, c};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int id, input logic [31:0] seq);
    exp_t e;
    e.id = 2'(id);
    e.seq = seq;
    e.data = exp_data(id);
    exp_q.push_back(e);
  endtask

  task automatic wait_enable();
    int t;
    t = 0;
    @(negedge clk);
    while (!pl_enable && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!pl_enable) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_enable got=no_launch expected=launch");
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (busy && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (busy) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_idle got=busy expected=idle");
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_pl_enable"}, 128'(pl_enable), 128'd0);
    chk({tag, "_busy"}, 128'(busy), 128'd0);
    chk({tag, "_req_ready"}, 128'(req_ready), 128'd0);
    chk({tag, "_frames"}, 128'(frames_sent), 128'd0);
    chk({tag, "_timeout_err"}, 128'(timeout_err), 128'd0);
    chk({tag, "_seq"}, 128'(pl_seq_num), 128'd1);
    chk({tag, "_grant_id"}, 128'(pl_grant_id), 128'd0);
    chk({tag, "_req_data"}, 128'(pl_req_data), 128'd0);
    chk({tag, "_wrap_seq"}, 128'(w_pl_seq_num), 128'hFFFF_FFFF);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    resetn = 1'b1;
  endtask

  // Builder model: beats on the 1st-3rd cycles after launch, tlast on the 4th.
  initial begin
    pl_tvalid = 1'b0;
    pl_tlast  = 1'b0;
    forever begin
      @(negedge clk);
      if (pl_enable && !withhold) begin
        repeat (3) begin
          @(negedge clk);
          pl_tvalid = 1'b1;
          pl_tlast  = 1'b0;
        end
        @(negedge clk);
        pl_tlast = 1'b1;
        @(negedge clk);
        pl_tvalid = 1'b0;
        pl_tlast  = 1'b0;
      end
    end
  end

  // Monitor: every launch is popped from the scoreboard and compared.
  initial begin
    int   cyc, prev_cyc;
    bit   have_prev;
    exp_t e;
    cyc = 0;
    prev_cyc = 0;
    have_prev = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (pl_enable) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_launch got id=%0d seq=%0h expected=none", pl_grant_id, pl_seq_num);
        end else begin
          e = exp_q.pop_front();
          if (pl_grant_id !== e.id || pl_seq_num !== e.seq || pl_req_data !== e.data) begin
            n_errors++;
            $display("FAIL launch got id=%0d seq=%0h data=%0h expected id=%0d seq=%0h data=%0h",
                     pl_grant_id, pl_seq_num, pl_req_data, e.id, e.seq, e.data);
          end
        end
        if (spacing_on) begin
          if (have_prev) begin
            n_checks++;
            if (cyc - prev_cyc != 8) begin
              n_errors++;
              $display("FAIL launch_spacing got=%0d expected=8", cyc - prev_cyc);
            end
          end
          have_prev = 1'b1;
          prev_cyc = cyc;
        end else begin
          have_prev = 1'b0;
        end
      end else if (!spacing_on) begin
        have_prev = 1'b0;
      end
    end
  end

  initial begin
    resetn    = 1'b0;
    req_valid = '0;
    tx_ready  = 1'b1;
    for (int i = 0; i < NREQ; i++) req_data[i*RW +: RW] = exp_data(i);
    repeat (3) @(negedge clk);
    check_reset_vals("init");
    resetn = 1'b1;

    // Single order from requester 0
    @(negedge clk);
    push_exp(0, 32'd1);
    req_valid = 4'b0001;
    #1;
    chk("single_req_ready", 128'(req_ready), 128'b0001);
    wait_enable();
    req_valid = '0;
    wait_idle();
    chk("single_frames", 128'(frames_sent), 128'd1);
    chk("single_seq", 128'(pl_seq_num), 128'd2);
    chk("wrap_seq_after_ffffffff", 128'(w_pl_seq_num), 128'd1);

    // Eight frames with all requesters pending: RR order 0,1,2,3,0,1,2,3
    do_reset();
    for (int n = 0; n < 8; n++) push_exp(n % 4, 32'(n + 1));
    spacing_on = 1'b1;
    @(negedge clk);
    req_valid = 4'b1111;
    for (int n = 0; n < 8; n++) wait_enable();
    req_valid = '0;
    wait_idle();
    spacing_on = 1'b0;
    chk("burst_frames", 128'(frames_sent), 128'd8);
    chk("burst_seq", 128'(pl_seq_num), 128'd9);
    chk("burst_wrap_seq", 128'(w_pl_seq_num), 128'd8);
    chk("burst_queue_drained", 128'(exp_q.size()), 128'd0);

    // Builder withholds tlast: timeout after 8 WAIT_LAST cycles
    withhold = 1'b1;
    push_exp(2, 32'd9);
    req_valid = 4'b0100;
    wait_enable();
    req_valid = '0;
    repeat (8) @(negedge clk);
    chk("timeout_not_yet", 128'(timeout_err), 128'd0);
    @(negedge clk);
    chk("timeout_err_set", 128'(timeout_err), 128'd1);
    chk("timeout_seq", 128'(pl_seq_num), 128'd10);
    chk("timeout_frames", 128'(frames_sent), 128'd8);
    wait_idle();
    withhold = 1'b0;

    // Next request still launches after a timeout
    push_exp(3, 32'd10);
    req_valid = 4'b1000;
    wait_enable();
    req_valid = '0;
    wait_idle();
    chk("post_timeout_frames", 128'(frames_sent), 128'd9);
    chk("post_timeout_seq", 128'(pl_seq_num), 128'd11);
    chk("timeout_err_sticky", 128'(timeout_err), 128'd1);

    // tx_ready low in IDLE blocks launch; dropping it mid-frame has no effect
    tx_ready = 1'b0;
    req_valid = 4'b0001;
    #1;
    chk("txoff_req_ready", 128'(req_ready), 128'd0);
    repeat (10) @(negedge clk);
    chk("txoff_busy", 128'(busy), 128'd0);
    push_exp(0, 32'd11);
    tx_ready = 1'b1;
    #1;
    chk("txon_req_ready", 128'(req_ready), 128'b0001);
    wait_enable();
    req_valid = '0;
    tx_ready = 1'b0;
    wait_idle();
    tx_ready = 1'b1;
    chk("txdrop_frames", 128'(frames_sent), 128'd10);
    chk("txdrop_seq", 128'(pl_seq_num), 128'd12);

    // Reset asserted during WAIT_LAST
    push_exp(1, 32'd12);
    req_valid = 4'b0010;
    wait_enable();
    req_valid = '0;
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check_reset_vals("midframe_reset");
    @(negedge clk);
    resetn = 1'b1;
    repeat (15) @(negedge clk);
    chk("after_reset_frames", 128'(frames_sent), 128'd0);
    chk("after_reset_busy", 128'(busy), 128'd0);
    chk("final_queue_drained", 128'(exp_q.size()), 128'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
